// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths and FSM state encoding for the fetch front end
package inst_fetch_pkg;
  localparam int INSTMEM_ADDR_WIDTH = 16;
  localparam int INSTR_WIDTH = 32;
  typedef enum logic {ST_RUN = 1'b0, ST_REDIR = 1'b1} state_e;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory request/response and decoder handshake bundle
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W  = INSTMEM_ADDR_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH
);
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               inst_valid;
  logic [INSTR_W-1:0] inst_data;
  logic [ADDR_W-1:0]  inst_pc;
  logic               inst_ready;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// fetch_queue: in-order buffer of {pc, data}; entries are allocated at tail, filled at fill pointer, popped at head
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = INSTMEM_ADDR_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc,
  input  logic [ADDR_W-1:0]          alloc_pc,
  input  logic                       fill,
  input  logic [INSTR_W-1:0]         fill_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [ADDR_W-1:0]          head_pc,
  output logic [INSTR_W-1:0]         head_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] unfilled
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
  logic [CW-1:0] cnt_q, cnt_d, ucnt_q, ucnt_d;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];
  logic [INSTR_W-1:0] data_q [DEPTH];
  logic [INSTR_W-1:0] data_d [DEPTH];
  logic pop_ok;
  // Filled entries run from head up to the fill pointer, so the head is filled whenever any entry is.
  assign head_valid = cnt_q != ucnt_q;
  assign head_pc    = pc_q[head_q];
  assign head_data  = data_q[head_q];
  assign occupancy  = cnt_q;
  assign unfilled   = ucnt_q;
  assign pop_ok     = pop & head_valid;
  // Pointer and storage update; a flush empties everything and overrides the other operations.
  always_comb begin
    head_d = pop_ok ? head_q + PW'(1) : head_q;
    tail_d = alloc ? tail_q + PW'(1) : tail_q;
    fptr_d = fill ? fptr_q + PW'(1) : fptr_q;
    cnt_d  = cnt_q + CW'(alloc) - CW'(pop_ok);
    ucnt_d = ucnt_q + CW'(alloc) - CW'(fill);
    pc_d   = pc_q;
    data_d = data_q;
    if (alloc) pc_d[tail_q] = alloc_pc;
    if (fill) data_d[fptr_q] = fill_data;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      fptr_d = '0;
      cnt_d  = '0;
      ucnt_d = '0;
    end
  end
  // Queue state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      fptr_q <= '0;
      cnt_q  <= '0;
      ucnt_q <= '0;
      pc_q   <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fptr_q <= fptr_d;
      cnt_q  <= cnt_d;
      ucnt_q <= ucnt_d;
      pc_q   <= pc_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch front end; credit-limited requests, PC control, branch redirect and flush
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = INSTMEM_ADDR_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  output logic              incPC,
  output logic              loadFromI,
  output logic [ADDR_W-1:0] I,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  inst_fetch_if.master      bus
);
  localparam int CW = $clog2(DEPTH+1);
  state_e state_q, state_d;
  logic [CW-1:0] drop_q, drop_d, occupancy, unfilled;
  logic load_q, load_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [CW:0] inflight;
  logic req_valid, fire, dropping, fill, pop;
  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .alloc     (fire),
    .alloc_pc  (Address),
    .fill      (fill),
    .fill_data (bus.imem_rsp_data),
    .pop       (pop),
    .flush     (branch_valid),
    .head_valid(bus.inst_valid),
    .head_pc   (bus.inst_pc),
    .head_data (bus.inst_data),
    .occupancy (occupancy),
    .unfilled  (unfilled)
  );
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = Address;
  assign incPC              = fire;
  assign loadFromI          = load_q;
  assign I                  = i_q;
  // Request credit, response steering, redirect FSM and outstanding-drop accounting.
  always_comb begin
    inflight  = {1'b0, occupancy} + {1'b0, drop_q};
    req_valid = reset & (state_q == ST_RUN) & !branch_valid & (inflight < (CW+1)'(DEPTH));
    fire      = req_valid & bus.imem_req_ready;
    dropping  = drop_q != '0;
    fill      = bus.imem_rsp_valid & !dropping & !branch_valid;
    pop       = bus.inst_valid & bus.inst_ready & !branch_valid;
    state_d   = branch_valid ? ST_REDIR : ST_RUN;
    load_d    = branch_valid;
    i_d       = branch_valid ? branch_target : i_q;
    drop_d    = branch_valid ? drop_q + unfilled - CW'(bus.imem_rsp_valid)
                             : drop_q - CW'(bus.imem_rsp_valid & dropping);
  end
  // FSM, redirect and drop counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      drop_q  <= '0;
      load_q  <= 1'b0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      load_q  <= load_d;
      i_q     <= i_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized bench for inst_fetch against a queue-based fetch/memory model
module tb_inst_fetch;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] Address;
  logic incPC, loadFromI;
  logic [15:0] I;
  logic branch_valid;
  logic [15:0] branch_target;
  inst_fetch_if #(.ADDR_W(16), .INSTR_W(32)) bus ();
  inst_fetch #(.DEPTH(DEPTH), .ADDR_W(16), .INSTR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .incPC        (incPC),
    .loadFromI    (loadFromI),
    .I            (I),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .bus          (bus)
  );
  always #5 clk = ~clk;
  typedef struct {logic [15:0] pc; bit filled;} ent_t;
  typedef struct {logic [15:0] addr; bit stale;} req_t;
  ent_t live[$];
  req_t mq[$];
  bit redir_m;
  logic [15:0] i_m, pc_m;
  int n_chk = 0, n_fail = 0, pops = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] fdata(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction
  function automatic int nstale();
    int n = 0;
    foreach (mq[k]) if (mq[k].stale) n++;
    return n;
  endfunction
  task automatic step(input int p_br, input int p_rsp, input int p_rdy, input int p_ir);
    bit br, rv, rdy, ir, exp_rv, exp_fire, exp_iv, found;
    logic [15:0] bt;
    req_t r;
    @(negedge clk);
    br = ($urandom % 100) < p_br;
    rv = mq.size() > 0 && ($urandom % 100) < p_rsp;
    rdy = ($urandom % 100) < p_rdy;
    ir = ($urandom % 100) < p_ir;
    bt = 16'($urandom);
    Address = pc_m;
    branch_valid = br;
    branch_target = bt;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data = rv ? fdata(mq[0].addr) : $urandom;
    bus.imem_req_ready = rdy;
    bus.inst_ready = ir;
    #1;
    exp_rv = !redir_m && !br && (live.size() + nstale() < DEPTH);
    exp_fire = exp_rv && rdy;
    exp_iv = live.size() > 0 && live[0].filled;
    chk("req_valid", bus.imem_req_valid, exp_rv);
    chk("incPC", incPC, exp_fire);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, pc_m);
    chk("loadFromI", loadFromI, redir_m);
    if (redir_m) chk("I", I, i_m);
    chk("inst_valid", bus.inst_valid, exp_iv);
    if (exp_iv) begin
      chk("inst_pc", bus.inst_pc, live[0].pc);
      chk("inst_data", bus.inst_data, fdata(live[0].pc));
    end
    @(posedge clk);
    if (exp_iv && ir && !br) begin
      void'(live.pop_front());
      pops++;
    end
    if (rv) begin
      r = mq.pop_front();
      found = 0;
      if (!r.stale)
        foreach (live[k])
          if (!live[k].filled && !found) begin
            live[k].filled = 1;
            found = 1;
          end
      assert (r.stale || found) else $error("response with no unfilled entry and nothing to drop");
    end
    if (exp_fire) begin
      live.push_back('{pc: pc_m, filled: 1'b0});
      mq.push_back('{addr: pc_m, stale: 1'b0});
    end
    if (br) begin
      live.delete();
      foreach (mq[k]) mq[k].stale = 1;
    end
    if (exp_fire) pc_m = pc_m + 16'd1;
    else if (redir_m) pc_m = i_m;
    redir_m = br;
    if (br) i_m = bt;
  endtask
  task automatic model_reset();
    live.delete();
    mq.delete();
    redir_m = 0;
    i_m = '0;
    pc_m = 16'h0010;
    Address = pc_m;
    branch_valid = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_req_ready = 0;
    bus.inst_ready = 0;
  endtask
  initial begin
    branch_target = '0;
    bus.imem_rsp_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_incPC", incPC, 0);
    chk("rst_loadFromI", loadFromI, 0);
    chk("rst_I", I, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 100, 100, 100);
    repeat (40) step(0, 100, 100, 100);
    repeat (10) step(0, 100, 100, 0);
    repeat (10) step(0, 100, 100, 100);
    repeat (300) step(15, 60, 70, 70);
    repeat (300) step(35, 85, 90, 90);
    @(negedge clk);
    bus.imem_req_ready = 1;
    #2 reset = 1'b0;
    #1;
    chk("arst_req_valid", bus.imem_req_valid, 0);
    chk("arst_incPC", incPC, 0);
    chk("arst_loadFromI", loadFromI, 0);
    chk("arst_inst_valid", bus.inst_valid, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) step(20, 70, 80, 80);
    repeat (100) step(0, 100, 100, 100);
    chk("progress", pops > 200, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
